mem_access_unit: RTL

//  Parametrised MEM pipeline stage between EX and MEM/WB. Non-memory ops pass straight through.

---
 rtl/mem_access_unit.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module : mem_access_unit
// Purpose: MEM pipeline stage between EX and MEM/WB. Non-memory ops pass
//          straight through with no added latency. Loads and stores drive a
//          req/ack data-memory port and stall the pipeline until the access
//          completes. Byte and word accesses use byte-lane enables; byte
//          loads are sign- or zero-extended.
// Ports  : clk, rst (sync, active-high)
//          EX side   : wd_i, wreg_i, wdata_i, hi_i, lo_i, whilo_i,
//                      mem_op_i, mem_addr_i, mem_sdata_i
//          WB side   : wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o, stall_o
//          Memory    : mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
//                      mem_be_o, mem_rdata_i, mem_ack_i, mem_err_o
// Config : MEM_TIMEOUT_EN - when defined, a REQ lasting TIMEOUT_CYC cycles
//          without ack is aborted and flagged on mem_err_o.
// Rev    : 1.0  initial release
// ============================================================================
module mem_access_unit #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int REGA_W      = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REGA_W-1:0]   wd_i,
  input  logic                wreg_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W-1:0]   hi_i,
  input  logic [DATA_W-1:0]   lo_i,
  input  logic                whilo_i,
  input  logic [2:0]          mem_op_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_sdata_i,
  output logic [REGA_W-1:0]   wd_o,
  output logic                wreg_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic                whilo_o,
  output logic                stall_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_ack_i,
  output logic                mem_err_o
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state;
  logic [1:0] next_state;

  // Operation decode
  logic is_load, is_store, is_byte, is_signed, is_mem;
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_byte   = 1'b0;
    is_signed = 1'b0;
    case (mem_op_i)
      3'b001: is_load = 1'b1;
      3'b010: begin is_load = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
      3'b011: begin is_load = 1'b1; is_byte = 1'b1; end
      3'b101: is_store = 1'b1;
      3'b110: begin is_store = 1'b1; is_byte = 1'b1; end
      default: ;
    endcase
  end
  assign is_mem = is_load | is_store;

  logic [LANE_W-1:0] lane;
  assign lane = mem_addr_i[LANE_W-1:0];

  // Abort path: timed_out fires in the last permitted REQ cycle when no ack
  // is present, so a same-cycle ack always takes priority.
  logic timed_out;
  logic err_q;
`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] req_cnt;

  assign timed_out = (state == S_REQ) && !mem_ack_i &&
                     (req_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      req_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_REQ) req_cnt <= req_cnt + 1'b1;
      else                req_cnt <= '0;
      err_q <= timed_out;
    end
  end
`else
  assign timed_out = 1'b0;
  assign err_q     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (is_mem) next_state = S_REQ;
      S_REQ:   if (mem_ack_i || timed_out) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Access registers: captured on REQ entry and held stable through REQ
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [NB-1:0]     be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LANE_W-1:0] lane_q;
  logic              byte_q;
  logic              signed_q;
  logic [DATA_W-1:0] load_q;
  logic [7:0]        rd_byte;

  assign rd_byte = mem_rdata_i[{lane_q, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      lane_q   <= '0;
      byte_q   <= 1'b0;
      signed_q <= 1'b0;
      load_q   <= '0;
    end else begin
      if (state == S_IDLE && is_mem) begin
        addr_q   <= {mem_addr_i[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
        we_q     <= is_store;
        be_q     <= is_byte ? (NB'(1) << lane) : {NB{1'b1}};
        wdata_q  <= (is_store && is_byte) ? {NB{mem_sdata_i[7:0]}} : mem_sdata_i;
        lane_q   <= lane;
        byte_q   <= is_byte;
        signed_q <= is_signed;
      end
      if (state == S_REQ && mem_ack_i && !we_q) begin
        if (!byte_q)       load_q <= mem_rdata_i;
        else if (signed_q) load_q <= {{(DATA_W-8){rd_byte[7]}}, rd_byte};
        else               load_q <= {{(DATA_W-8){1'b0}}, rd_byte};
      end
    end
  end

  // Output logic; everything is held at zero while rst is asserted
  always_comb begin
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    hi_o        = '0;
    lo_o        = '0;
    whilo_o     = 1'b0;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    mem_err_o   = 1'b0;
    if (!rst) begin
      wd_o        = wd_i;
      wdata_o     = wdata_i;
      hi_o        = hi_i;
      lo_o        = lo_i;
      mem_we_o    = we_q;
      mem_addr_o  = addr_q;
      mem_wdata_o = wdata_q;
      mem_be_o    = be_q;
      case (state)
        S_IDLE: begin
          stall_o = is_mem;
          wreg_o  = wreg_i & ~is_mem;
          whilo_o = whilo_i & ~is_mem;
        end
        S_REQ: begin
          stall_o   = 1'b1;
          mem_req_o = 1'b1;
        end
        S_DONE: begin
          whilo_o   = whilo_i;
          mem_err_o = err_q;
          if (!we_q) begin
            wdata_o = load_q;
            wreg_o  = wreg_i & ~err_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
